// File: rtl/axi_lite_cfg_slave.sv
// rtl/axi_lite_cfg_slave.sv - AXI4-Lite config register slave with start/done handshake
// Optional CFG_SHADOW_EN: user register writes are staged and applied to cfg_regs on start.
module axi_lite_cfg_slave #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_LSB = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [31:0]             AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [31:0]             WDATA,
   input  logic [3:0]              WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [31:0]             ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [31:0]             RDATA,
   output logic [1:0]              RRESP,
   output logic                    RVALID,
   input  logic                    RREADY,
   input  logic                    done_in,
   output logic                    start_out,
   output logic [32*NUM_REGS-1:0]  cfg_regs
);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [7:0]  WORD_CTRL   = 8'h00;
   localparam logic [7:0]  WORD_STATUS = 8'h01;
   localparam logic [7:0]  WORD_ID     = 8'h02;
   localparam logic [8:0]  USER_FIRST  = 9'd4;
   localparam logic [8:0]  USER_END    = 9'(4 + NUM_REGS);
   localparam logic [31:0] ID_VALUE    = 32'h4346_0000 | 32'(NUM_REGS);

   logic [7:0]  aw_word_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic [31:0] user_q [NUM_REGS];
   logic        done_q;
   logic        busy_q;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic        commit;
   logic [7:0]  wr_word, rd_word;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_user, wr_ok;
   logic        start_c, done_clr_c;
   logic [31:0] rd_data_c;
   logic        rd_ok_c;
   logic        unused_addr;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   assign unused_addr = ^{AWADDR, ARADDR};

   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign b_hs    = BVALID & BREADY;
   assign ar_hs   = ARVALID & ARREADY;
   assign r_hs    = RVALID & RREADY;
   assign ARREADY = ~RVALID;

   // A dropped READY means the beat is held; otherwise use the live bus so a
   // same-cycle AW/W pair commits immediately.
   assign wr_word = AWREADY ? AWADDR[ADDR_LSB+7:ADDR_LSB] : aw_word_q;
   assign wr_data = WREADY ? WDATA : w_data_q;
   assign wr_strb = WREADY ? WSTRB : w_strb_q;
   assign commit  = (aw_hs | ~AWREADY) & (w_hs | ~WREADY) & ~BVALID;

   assign wr_user    = ({1'b0, wr_word} >= USER_FIRST) && ({1'b0, wr_word} < USER_END);
   assign wr_ok      = (wr_word == WORD_CTRL) || (wr_word == WORD_STATUS) || wr_user;
   assign start_c    = commit && (wr_word == WORD_CTRL) && wr_strb[0] && wr_data[0];
   assign done_clr_c = commit && (wr_word == WORD_STATUS) && wr_strb[0] && wr_data[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         AWREADY   <= 1'b1;
         WREADY    <= 1'b1;
         BVALID    <= 1'b0;
         BRESP     <= RESP_OKAY;
         aw_word_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) begin
            AWREADY   <= 1'b0;
            aw_word_q <= AWADDR[ADDR_LSB+7:ADDR_LSB];
         end
         if (w_hs) begin
            WREADY   <= 1'b0;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
         end
         if (commit) begin
            BVALID <= 1'b1;
            BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (b_hs) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_out <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) user_q[i] <= '0;
      end else begin
         start_out <= start_c;
         if (start_c)      busy_q <= 1'b1;
         else if (done_in) busy_q <= 1'b0;
         // A completion arriving with a W1C keeps DONE set.
         if (done_in)         done_q <= 1'b1;
         else if (done_clr_c) done_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (wr_word == 8'(4 + i)))
               user_q[i] <= byte_merge(user_q[i], wr_data, wr_strb);
         end
      end
   end

   assign rd_word = ARADDR[ADDR_LSB+7:ADDR_LSB];

   always_comb begin
      rd_data_c = '0;
      rd_ok_c   = 1'b1;
      case (rd_word)
         WORD_CTRL:   rd_data_c = '0;
         WORD_STATUS: rd_data_c = {30'b0, busy_q, done_q};
         WORD_ID:     rd_data_c = ID_VALUE;
         default: begin
            rd_ok_c = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (rd_word == 8'(4 + i)) begin
                  rd_data_c = user_q[i];
                  rd_ok_c   = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         RVALID <= 1'b0;
         RDATA  <= '0;
         RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         RVALID <= 1'b1;
         RDATA  <= rd_data_c;
         RRESP  <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
         RVALID <= 1'b0;
      end
   end

`ifdef CFG_SHADOW_EN
   logic [31:0] live_q [NUM_REGS];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) live_q[i] <= '0;
      end else if (start_c) begin
         for (int i = 0; i < NUM_REGS; i++) live_q[i] <= user_q[i];
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_shadow
      assign cfg_regs[32*g +: 32] = live_q[g];
   end
`else
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_direct
      assign cfg_regs[32*g +: 32] = user_q[g];
   end
`endif

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
// tb/tb_axi_lite_cfg_slave.sv - randomized scoreboard bench for axi_lite_cfg_slave
module tb_axi_lite_cfg_slave;
   localparam int N = 8;
   localparam int W = 32 * N;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [31:0]   AWADDR = '0;
   logic          AWVALID = 1'b0;
   logic          AWREADY;
   logic [31:0]   WDATA = '0;
   logic [3:0]    WSTRB = '0;
   logic          WVALID = 1'b0;
   logic          WREADY;
   logic [1:0]    BRESP;
   logic          BVALID;
   logic          BREADY = 1'b0;
   logic [31:0]   ARADDR = '0;
   logic          ARVALID = 1'b0;
   logic          ARREADY;
   logic [31:0]   RDATA;
   logic [1:0]    RRESP;
   logic          RVALID;
   logic          RREADY = 1'b0;
   logic          done_in = 1'b0;
   logic          start_out;
   logic [W-1:0]  cfg_regs;

   always #5 clock = ~clock;

   axi_lite_cfg_slave #(.NUM_REGS(N), .ADDR_LSB(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .done_in(done_in), .start_out(start_out), .cfg_regs(cfg_regs)
   );

   int          checks = 0;
   int          errors = 0;
   logic [1:0]  exp_b_q [$];
   logic [33:0] exp_r_q [$];
   logic [31:0] m_regs [N];
   logic [31:0] m_live [N];
   logic        m_done, m_busy;
   int          exp_starts = 0;
   int          seen_starts = 0;
   logic [1:0]  mon_b;
   logic [33:0] mon_r;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_regs[i] = '0;
         m_live[i] = '0;
      end
      m_done = 1'b0;
      m_busy = 1'b0;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) & 32'hFF);
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                              input logic [3:0] s, input bit with_done);
      int w;
      w = word_of(a);
      if (with_done) begin
         m_done = 1'b1;
         m_busy = 1'b0;
      end
      if (w == 0) begin
         if (s[0] && d[0]) begin
            m_busy = 1'b1;
            exp_starts++;
            for (int i = 0; i < N; i++) m_live[i] = m_regs[i];
         end
         return 2'b00;
      end
      if (w == 1) begin
         if (!with_done && s[0] && d[0]) m_done = 1'b0;
         return 2'b00;
      end
      if (w >= 4 && w < 4 + N) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) m_regs[w-4][8*b +: 8] = d[8*b +: 8];
`ifndef CFG_SHADOW_EN
         m_live[w-4] = m_regs[w-4];
`endif
         return 2'b00;
      end
      return 2'b10;
   endfunction

   function automatic logic [33:0] model_read(input logic [31:0] a);
      int w;
      w = word_of(a);
      if (w == 0) return {2'b00, 32'h0};
      if (w == 1) return {2'b00, 30'b0, m_busy, m_done};
      if (w == 2) return {2'b00, 32'h4346_0000 | 32'(N)};
      if (w >= 4 && w < 4 + N) return {2'b00, m_regs[w-4]};
      return {2'b10, 32'h0};
   endfunction

   function automatic logic [W-1:0] model_cfg();
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[32*i +: 32] = m_live[i];
      return v;
   endfunction

   function automatic logic [31:0] pick_addr();
      int k;
      logic [31:0] base;
      k = $urandom_range(0, 9);
      case (k)
         0: base = 32'h00;
         1: base = 32'h04;
         2: base = 32'h08;
         3: base = 32'h0C;
         4: base = 32'h200;
         5: base = 32'h10 + 32'(4 * N);
         default: base = 32'h10 + 32'(4 * $urandom_range(0, N - 1));
      endcase
      return base | (32'($urandom_range(0, 255)) << 10) | 32'($urandom_range(0, 3));
   endfunction

   task automatic check_reset_outputs();
      chk("rst_awready", AWREADY, 1);
      chk("rst_wready", WREADY, 1);
      chk("rst_arready", ARREADY, 1);
      chk("rst_bvalid", BVALID, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_bresp", BRESP, 0);
      chk("rst_rresp", RRESP, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_start", start_out, 0);
      chk("rst_cfg", cfg_regs, 0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd, input bit with_done);
      logic [1:0] exp_resp;
      logic       exp_start;
      exp_start = (word_of(a) == 0) && s[0] && d[0];
      exp_resp  = model_write(a, d, s, with_done);
      exp_b_q.push_back(exp_resp);
      fork
         begin
            int t = 0;
            repeat (awd) begin @(posedge clock); #1; end
            AWADDR = a; AWVALID = 1'b1;
            @(negedge clock);
            while (!AWREADY && t < 50) begin @(negedge clock); t++; end
            if (t >= 50) begin checks++; errors++; $display("FAIL aw_timeout: AWREADY %b required 1", AWREADY); end
            @(posedge clock); #1 AWVALID = 1'b0;
         end
         begin
            int t = 0;
            repeat (wd) begin @(posedge clock); #1; end
            WDATA = d; WSTRB = s; WVALID = 1'b1;
            @(negedge clock);
            while (!WREADY && t < 50) begin @(negedge clock); t++; end
            if (t >= 50) begin checks++; errors++; $display("FAIL w_timeout: WREADY %b required 1", WREADY); end
            @(posedge clock); #1 WVALID = 1'b0;
         end
         begin
            if (with_done) begin
               done_in = 1'b1;
               @(posedge clock); #1 done_in = 1'b0;
            end
         end
      join
      chk("b_latency", BVALID, 1);
      chk("start_pulse", start_out, exp_start);
      chk("cfg_after_write", cfg_regs, model_cfg());
      @(posedge clock); #1;
      chk("start_width", start_out, 0);
      repeat (bd) begin
         @(posedge clock); #1;
         chk("b_hold_valid", BVALID, 1);
         chk("b_hold_resp", BRESP, exp_resp);
      end
      BREADY = 1'b1;
      @(posedge clock); #1 BREADY = 1'b0;
      chk("b_drop", BVALID, 0);
      chk("aw_rearm", AWREADY, 1);
      chk("w_rearm", WREADY, 1);
   endtask

   task automatic do_read(input logic [31:0] a, input int ard, input int rd, input bit push);
      int t = 0;
      if (push) exp_r_q.push_back(model_read(a));
      repeat (ard) begin @(posedge clock); #1; end
      ARADDR = a; ARVALID = 1'b1;
      @(negedge clock);
      while (!ARREADY && t < 50) begin @(negedge clock); t++; end
      if (t >= 50) begin checks++; errors++; $display("FAIL ar_timeout: ARREADY %b required 1", ARREADY); end
      @(posedge clock); #1 ARVALID = 1'b0;
      chk("r_latency", RVALID, 1);
      chk("ar_blocked", ARREADY, 0);
      repeat (rd) begin
         @(posedge clock); #1;
         chk("r_hold", RVALID, 1);
      end
      RREADY = 1'b1;
      @(posedge clock); #1 RREADY = 1'b0;
      chk("ar_rearm", ARREADY, 1);
   endtask

   task automatic pulse_done();
      done_in = 1'b1;
      @(posedge clock); #1 done_in = 1'b0;
      m_done = 1'b1;
      m_busy = 1'b0;
   endtask

   // Scoreboard monitor: pops an expectation on every completed B or R handshake.
   always @(negedge clock) begin
      if (reset_n) begin
         if (start_out) seen_starts++;
         if (BVALID && BREADY) begin
            if (exp_b_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected: BRESP %0h with no write outstanding", BRESP);
            end else begin
               mon_b = exp_b_q.pop_front();
               chk("bresp", BRESP, mon_b);
            end
         end
         if (RVALID && RREADY) begin
            if (exp_r_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL r_unexpected: RDATA %0h with no read outstanding", RDATA);
            end else begin
               mon_r = exp_r_q.pop_front();
               chk("rdata", RDATA, mon_r[31:0]);
               chk("rresp", RRESP, mon_r[33:32]);
            end
         end
      end
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_reset_outputs();
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Reset in the middle of a write: AW accepted, W never sent.
      do_write(32'h18, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0);
      AWADDR = 32'h14; AWVALID = 1'b1;
      @(negedge clock);
      @(posedge clock); #1 AWVALID = 1'b0;
      chk("aw_held", AWREADY, 0);
      @(posedge clock); #3 reset_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clock); #1 reset_n = 1'b1;
      repeat (5) begin
         @(posedge clock); #1;
         chk("no_b_after_reset", BVALID, 0);
      end

      do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
      chk("t2_cfg0", cfg_regs[31:0], 32'hDEAD_BEEF);
      do_read(32'h10, 0, 0, 1);

      do_write(32'h14, 32'h1122_3344, 4'hF, 0, 0, 0, 0);
      do_write(32'h14, 32'h0000_AB00, 4'b0010, 3, 0, 5, 0);
      chk("t3_reg1", cfg_regs[63:32], 32'h1122_AB44);
      do_read(32'h14, 1, 2, 1);

      do_write(32'h00, 32'h1, 4'hF, 0, 0, 0, 0);
      do_read(32'h04, 0, 0, 1);
      do_read(32'h00, 0, 0, 1);
      pulse_done();
      do_read(32'h04, 0, 0, 1);
      do_write(32'h04, 32'h1, 4'hF, 0, 0, 0, 1);
      do_read(32'h04, 0, 0, 1);
      do_write(32'h04, 32'h1, 4'hE, 0, 0, 0, 0);
      do_read(32'h04, 0, 0, 1);
      do_write(32'h04, 32'h1, 4'h1, 0, 0, 0, 0);
      do_read(32'h04, 0, 0, 1);

      do_write(32'h200, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
      do_read(32'h200, 0, 0, 1);
      do_write(32'h08, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
      do_read(32'h08, 0, 0, 1);

      // Read racing a write to the same register sees the old value.
      do_write(32'h18, 32'h0000_1111, 4'hF, 0, 0, 0, 0);
      exp_r_q.push_back(model_read(32'h18));
      fork
         do_read(32'h18, 0, 0, 0);
         do_write(32'h18, 32'h0000_2222, 4'hF, 0, 0, 0, 0);
      join
      do_read(32'h18, 0, 0, 1);

      do_write(32'h10, 32'h5, 4'hF, 0, 0, 0, 0);
      do_read(32'h10, 0, 0, 1);
      do_write(32'h00, 32'h1, 4'h1, 0, 2, 0, 0);
      chk("t6_cfg0", cfg_regs[31:0], 32'h5);
      pulse_done();

      for (int it = 0; it < 80; it++) begin
         int op;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         a  = pick_addr();
         if (op < 5)
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2), 0);
         else if (op < 9)
            do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), 1);
         else
            pulse_done();
      end

      repeat (4) @(posedge clock);
      #1;
      chk("b_queue_empty", exp_b_q.size(), 0);
      chk("r_queue_empty", exp_r_q.size(), 0);
      chk("start_count", seen_starts, exp_starts);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
